// File: rtl/fact_core.sv
// Memory-mapped factorial accelerator: n/go registers, iterative n! engine, read mux.
// Optional FACT_IRQ_EN adds a one-cycle Irq pulse after each completion.
module fact_core #(
  parameter int WIDTH  = 32,
  parameter int NWIDTH = 4,
  parameter int MAX_N  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WE1,
  input  logic             WE2,
  input  logic [WIDTH-1:0] WD,
  input  logic [1:0]       RdSel,
  output logic [WIDTH-1:0] RD,
  output logic             Done,
  output logic             Err
`ifdef FACT_IRQ_EN
  ,
  output logic             Irq
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [NWIDTH-1:0] MAXN_L = NWIDTH'(MAX_N);
  localparam logic [NWIDTH-1:0] ONE_L  = NWIDTH'(1);

  state_t            r_state, w_next;
  logic [NWIDTH-1:0] r_n, r_cnt;
  logic [WIDTH-1:0]  r_result;
  logic              r_go, r_done, r_err;

  logic              w_busy, w_start, w_bad, w_last, w_enter_done;
  logic [WIDTH-1:0]  w_cnt_ext, w_prod;
  logic              w_unused;

  assign w_busy       = (r_state == S_BUSY);
  assign w_start      = WE2 & WD[0] & ~w_busy;
  assign w_bad        = (r_n > MAXN_L);
  assign w_last       = (r_cnt <= ONE_L);
  // Error starts re-enter DONE directly, possibly from DONE itself.
  assign w_enter_done = (w_busy & w_last) | (w_start & w_bad);
  assign w_cnt_ext    = {{(WIDTH-NWIDTH){1'b0}}, r_cnt};
  assign w_prod       = r_result * w_cnt_ext;
  assign w_unused     = ^WD[WIDTH-1:NWIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start) w_next = w_bad ? S_DONE : S_BUSY;
      S_BUSY:         if (w_last)  w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n      <= '0;
      r_go     <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (WE1 && !w_busy) r_n <= WD[NWIDTH-1:0];

      if (w_enter_done)       r_go <= 1'b0;
      else if (WE2 && !w_busy) r_go <= WD[0];

      if (w_start) begin
        if (w_bad) begin
          r_err    <= 1'b1;
          r_result <= '0;
          r_done   <= 1'b1;
        end else begin
          r_err    <= 1'b0;
          r_cnt    <= r_n;
          r_result <= WIDTH'(1);
          r_done   <= 1'b0;
        end
      end else if (w_busy) begin
        if (w_last) begin
          r_done <= 1'b1;
        end else begin
          r_result <= w_prod;
          r_cnt    <= r_cnt - ONE_L;
        end
      end
    end
  end

`ifdef FACT_IRQ_EN
  logic r_enter_q, r_irq;
  // Delay one edge so Irq rises the cycle after DONE is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enter_q <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_enter_q <= w_enter_done;
      r_irq     <= r_enter_q;
    end
  end
  assign Irq = r_irq;
`endif

  always_comb begin
    RD = '0;
    case (RdSel)
      2'b00:   RD[NWIDTH-1:0] = r_n;
      2'b01:   RD[0]          = r_go;
      2'b10:   RD[1:0]        = {r_err, r_done};
      default: RD             = r_result;
    endcase
  end

  assign Done = r_done;
  assign Err  = r_err;

endmodule

// File: tb/tb_fact_core.sv
// Directed, table-driven bench for fact_core with hand-written busy/reset sequences.
module tb_fact_core;

  logic        clk, rst, WE1, WE2;
  logic [31:0] WD, RD;
  logic [1:0]  RdSel;
  logic        Done, Err;
`ifdef FACT_IRQ_EN
  logic        Irq;
`endif

  int tests = 0, fails = 0, ncomp = 0, nirq = 0;

  fact_core #(.WIDTH(32), .NWIDTH(4), .MAX_N(12)) dut (
    .clk(clk), .rst(rst), .WE1(WE1), .WE2(WE2), .WD(WD), .RdSel(RdSel),
    .RD(RD), .Done(Done), .Err(Err)
`ifdef FACT_IRQ_EN
    , .Irq(Irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FACT_IRQ_EN
  always @(posedge clk) if (Irq) nirq++;
`endif

  typedef struct {
    logic [3:0]  n;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] sel, output logic [31:0] v);
    RdSel = sel;
    #1 v = RD;
  endtask

  task automatic write_n(input logic [31:0] v);
    @(negedge clk); WE1 = 1'b1; WD = v;
    @(negedge clk); WE1 = 1'b0; WD = '0;
  endtask

  // Caller has just passed the start edge (+#1); returns edges until Done, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    if (Done) lat = 0;
    else for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (Done) begin lat = k; break; end
    end
    if (lat >= 0) ncomp++;
  endtask

  task automatic start_and_wait(output int lat);
    @(negedge clk); WE2 = 1'b1; WD = 32'd1;
    @(posedge clk); #1; WE2 = 1'b0; WD = '0;
    wait_done(lat);
  endtask

  initial begin
    logic [31:0] v;
    int lat;
    vt[0] = '{4'd5,  32'h0000_0078, 1'b0, 5};
    vt[1] = '{4'd12, 32'h1C8C_FC00, 1'b0, 12};
    vt[2] = '{4'd13, 32'h0000_0000, 1'b1, 0};
    vt[3] = '{4'd0,  32'h0000_0001, 1'b0, 1};
    vt[4] = '{4'd1,  32'h0000_0001, 1'b0, 1};
    vt[5] = '{4'd15, 32'h0000_0000, 1'b1, 0};
    vt[6] = '{4'd3,  32'h0000_0006, 1'b0, 3};
    vt[7] = '{4'd7,  32'h0000_13B0, 1'b0, 7};

    rst = 1'b1; WE1 = 1'b0; WE2 = 1'b0; WD = '0; RdSel = 2'b00;
    #12;
    for (int s = 0; s < 4; s++) begin
      rd(s[1:0], v);
      chk($sformatf("reset_rd%0d", s), v, 32'h0);
    end
    chk("reset_done", {31'b0, Done}, 32'h0);
    chk("reset_err",  {31'b0, Err},  32'h0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      write_n({28'b0, vt[i].n});
      start_and_wait(lat);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      @(negedge clk);
      rd(2'b00, v); chk($sformatf("v%0d_n", i), v, {28'b0, vt[i].n});
      rd(2'b01, v); chk($sformatf("v%0d_go", i), v, 32'h0);
      rd(2'b10, v); chk($sformatf("v%0d_status", i), v, {30'b0, vt[i].err, 1'b1});
      rd(2'b11, v); chk($sformatf("v%0d_result", i), v, vt[i].res);
    end

    // Writes to n and go during BUSY must be dropped.
    write_n(32'd6);
    @(negedge clk); WE2 = 1'b1; WD = 32'd1;
    @(posedge clk); #1; WE2 = 1'b0; WD = '0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      WE1 = (k == 2); WE2 = (k == 3);
      WD  = (k == 2) ? 32'd9 : (k == 3) ? 32'd1 : 32'd0;
      if (k == 3) begin
        rd(2'b01, v); chk("busy_go_set", v, 32'h1);
      end
      @(posedge clk); #1;
      if (Done) begin lat = k; break; end
    end
    WE1 = 1'b0; WE2 = 1'b0; WD = '0;
    if (lat >= 0) ncomp++;
    chk("busy_latency", lat, 6);
    @(negedge clk);
    rd(2'b00, v); chk("busy_n_kept", v, 32'd6);
    rd(2'b11, v); chk("busy_result", v, 32'h0000_02D0);
    rd(2'b01, v); chk("busy_go_clr", v, 32'h0);

    // Same-cycle n write and start: old n computed, new n kept.
    @(negedge clk); WE1 = 1'b1; WE2 = 1'b1; WD = 32'd3;
    @(posedge clk); #1; WE1 = 1'b0; WE2 = 1'b0; WD = '0;
    wait_done(lat);
    chk("simul_latency", lat, 6);
    @(negedge clk);
    rd(2'b11, v); chk("simul_result", v, 32'h0000_02D0);
    rd(2'b00, v); chk("simul_new_n", v, 32'd3);
    start_and_wait(lat);
    chk("simul_next_latency", lat, 3);
    @(negedge clk);
    rd(2'b11, v); chk("simul_next_result", v, 32'h6);

    // Reset mid-computation.
    write_n(32'd10);
    @(negedge clk); WE2 = 1'b1; WD = 32'd1;
    @(posedge clk); #1; WE2 = 1'b0; WD = '0;
    repeat (3) @(posedge clk);
    #1;
    rd(2'b11, v); chk("abort_partial", v, 32'h0000_02D0);
    rst = 1'b1;
    #1;
    chk("abort_done", {31'b0, Done}, 32'h0);
    chk("abort_err",  {31'b0, Err},  32'h0);
    for (int s = 0; s < 4; s++) begin
      rd(s[1:0], v);
      chk($sformatf("abort_rd%0d", s), v, 32'h0);
    end
    @(negedge clk); rst = 1'b0;
    write_n(32'd3);
    start_and_wait(lat);
    chk("post_rst_latency", lat, 3);
    @(negedge clk);
    rd(2'b11, v); chk("post_rst_result", v, 32'h6);
    rd(2'b10, v); chk("post_rst_status", v, 32'h1);

    repeat (4) @(posedge clk);
`ifdef FACT_IRQ_EN
    chk("irq_count", nirq, ncomp);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fact_core.md
Name: fact_core

Overview:
- Memory-mapped factorial accelerator core. It is the responder behind the factorial peripheral's address decoder.
- Holds the n and go registers, written through the decoder's per-register write enables.
- Computes n! iteratively, one multiply per cycle.
- Returns n, go, status or result on the read bus, selected by the decoder's 2-bit read select.

Parameters:
- WIDTH, 32, data bus and result width.
- NWIDTH, 4, width of the n register and the down-counter.
- MAX_N, 12, largest legal n. Constraint: MAX_N! < 2^WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- WE1  input  1  write enable for the n register (from the decoder).
- WE2  input  1  write enable for the go register (from the decoder).
- WD  input  WIDTH  write data from the CPU.
- RdSel  input  2  read select (from the decoder).
- RD  output  WIDTH  read data, combinational mux of registers.
- Done  output  1  computation complete (sticky).
- Err  output  1  n out of range (sticky).

Behaviour:
- Reset (async, rst=1):
  - n=0, go=0, cnt=0, result=0.
  - Done=0, Err=0, state=IDLE.
  - RD reflects the reset register values.
- n register:
  - On WE1, n <= WD[NWIDTH-1:0].
  - The write is ignored while state=BUSY.
- go register:
  - On WE2, go <= WD[0].
  - start = WE2 & WD[0] & (state != BUSY).
  - go auto-clears to 0 on the edge the FSM enters DONE.
- FSM states: IDLE, BUSY, DONE.
  - IDLE or DONE, on start:
    - Done <= 0.
    - If n > MAX_N: Err <= 1, result <= 0, next state DONE (Done=1 at that same edge).
    - Else: Err <= 0, cnt <= n, result <= 1, next state BUSY.
  - BUSY:
    - If cnt <= 1: next state DONE, Done <= 1.
    - Else: result <= result * cnt (truncated to WIDTH bits), cnt <= cnt - 1.
  - DONE: holds result, Done and Err until the next start.
- Latency:
  - Done rises on the edge max(n,1) cycles after the start edge.
  - Example: n=5, start at edge 0, multiplies at edges 1-4, Done=1 at edge 5.
  - n=0 and n=1 both give result=1 with Done at edge 1.
- Read map (combinational, no wait states):
  - RdSel 00: {0, n}.
  - RdSel 01: {0, go}.
  - RdSel 10: {0, Err, Done}.
  - RdSel 11: result.
- Simultaneous WE1 and start in the same cycle: start uses the old n. The new n is stored and is used by the next start.
- A start while BUSY is ignored; go is not updated.
- Reset asserted mid-computation aborts immediately to the reset values. No partial result is retained.

Optional Feature:
- Macro: FACT_IRQ_EN.
- Defined:
  - Adds output port Irq (1 bit, reset 0).
  - Irq pulses high for exactly one cycle on the edge after the FSM enters DONE, for both normal and error completion.
- Undefined:
  - The Irq port and its logic are absent.
  - Software polls RdSel=10.

Test Plan:
- Reset, then read all four RdSel values -> all read 0.
- Write n=5, write go=1 -> Done=1 exactly 5 cycles after the go edge; RdSel=11 reads 0x00000078; go reads 0.
- n=12, go -> Done after 12 cycles; result 0x1C8CFC00; Err=0.
- n=13, go -> Done=1 and Err=1 on the next edge; result 0; RdSel=10 reads 0x3.
- n=0, go -> result 1 after 1 cycle.
  - Then, while BUSY on a new n=6 run, write n=9 and go=1 -> both writes ignored; result 0x000002D0; n reads 6.
- Start n=10, assert rst at cycle 4 -> all outputs 0 immediately.
  - After release, n=3 plus go yields 0x6 in 3 cycles.
  - With FACT_IRQ_EN defined, Irq pulses once per completion.
